// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem handshake, and IF/ID register.
// Redirects from ID squash wrong-path fetches, including responses already in flight.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic [6:0]  ifid_opcode,
  output logic [4:0]  ifid_rs1,
  output logic [4:0]  ifid_rs2
);

  // state | meaning
  // REQ   | request presented at pc, waiting for grant
  // WAIT  | request accepted, waiting for response (kill set => drop it)
  // HOLD  | response buffered while the pipeline is stalled
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;

  logic        consume;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] deliver_pc;
  logic [31:0] target_aligned;
  logic        unused_target_bits;

  assign consume            = PCWrite & IFIDWrite;
  assign target_aligned     = {redirect_target[31:2], 2'b00};
  assign unused_target_bits = ^redirect_target[1:0];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_d      = buf_pc_q;
    ifid_valid_d  = ifid_valid_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_instr_d  = ifid_instr_q;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    deliver_pc    = pc_q;

    case (state_q)
      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
          // A redirect coincident with the grant makes that response stale.
          kill_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || redirect_valid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else if (consume) begin
            deliver = 1'b1;
            state_d = S_REQ;
          end else begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = pc_q;
            state_d     = S_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (consume) begin
          deliver       = 1'b1;
          deliver_instr = buf_instr_q;
          deliver_pc    = buf_pc_q;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (redirect_valid) begin
      pc_d = target_aligned;
    end else if (deliver) begin
      pc_d = pc_q + 32'd4;
    end

    if (redirect_valid) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (deliver) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = deliver_pc;
      ifid_instr_d = deliver_instr;
    end else if (IFIDWrite) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      buf_instr_q  <= NOP_INSTR;
      buf_pc_q     <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0000_0000;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  // Request is suppressed while reset is held so the reset cycle is quiet on the bus.
  assign imem_req    = (state_q == S_REQ) && !rst;
  assign imem_addr   = pc_q;
  assign ifid_valid  = ifid_valid_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_opcode = ifid_instr_q[6:0];
  assign ifid_rs1    = ifid_instr_q[19:15];
  assign ifid_rs2    = ifid_instr_q[24:20];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; a second instance with RESET_PC near the top checks PC wrap.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        PCWrite, IFIDWrite;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;

  logic        req_a, req_b;
  logic [31:0] addr_a, addr_b;
  logic        v_a, v_b;
  logic [31:0] pc_a, pc_b, ins_a, ins_b;
  logic [6:0]  op_a, op_b;
  logic [4:0]  rs1_a, rs1_b, rs2_a, rs2_b;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(req_a), .imem_addr(addr_a), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ifid_valid(v_a), .ifid_pc(pc_a), .ifid_instr(ins_a),
    .ifid_opcode(op_a), .ifid_rs1(rs1_a), .ifid_rs2(rs2_a)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(req_b), .imem_addr(addr_b), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ifid_valid(v_b), .ifid_pc(pc_b), .ifid_instr(ins_b),
    .ifid_opcode(op_b), .ifid_rs1(rs1_b), .ifid_rs2(rs2_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    PCWrite = 1'b1; IFIDWrite = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    n_cmp++;
    if ({req_a, addr_a} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL reset_bus got req=%b addr=%h exp req=0 addr=0", req_a, addr_a);
    end
    n_cmp++;
    if ({v_a, pc_a, ins_a, op_a, rs1_a, rs2_a} !== {1'b0, 32'h0, 32'h13, 7'h13, 5'd0, 5'd0}) begin
      n_err++; $display("FAIL reset_ifid got v=%b pc=%h ins=%h exp v=0 pc=0 ins=00000013", v_a, pc_a, ins_a);
    end
    n_cmp++;
    if ({req_b, addr_b} !== {1'b0, 32'hFFFF_FFFC}) begin
      n_err++; $display("FAIL reset_pc_param got req=%b addr=%h exp req=0 addr=fffffffc", req_b, addr_b);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({req_a, addr_a} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", req_a, addr_a);
    end
  endtask

  task automatic test_first_fetch();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    n_cmp++;
    if (req_a !== 1'b0) begin
      n_err++; $display("FAIL wait_req got %b exp 0", req_a);
    end
    step();
    imem_rvalid = 1'b0;
    n_cmp++;
    if ({v_a, pc_a, ins_a, op_a, rs1_a, rs2_a} !== {1'b1, 32'h0, 32'h0050_0093, 7'h13, 5'd0, 5'd5}) begin
      n_err++; $display("FAIL first_fetch got v=%b pc=%h ins=%h exp v=1 pc=0 ins=00500093", v_a, pc_a, ins_a);
    end
    n_cmp++;
    if ({req_a, addr_a} !== {1'b1, 32'h4}) begin
      n_err++; $display("FAIL next_addr got req=%b addr=%h exp req=1 addr=4", req_a, addr_a);
    end
    n_cmp++;
    if ({v_b, pc_b, ins_b, addr_b} !== {1'b1, 32'hFFFF_FFFC, 32'h0050_0093, 32'h0}) begin
      n_err++; $display("FAIL wrap got v=%b pc=%h ins=%h addr=%h exp v=1 pc=fffffffc ins=00500093 addr=0", v_b, pc_b, ins_b, addr_b);
    end
  endtask

  task automatic test_stall();
    PCWrite = 1'b0; IFIDWrite = 1'b0;
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0020_8133;
    step();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({req_a, v_a, pc_a, ins_a} !== {1'b0, 1'b1, 32'h0, 32'h0050_0093}) begin
        n_err++; $display("FAIL stall_hold[%0d] got req=%b v=%b pc=%h ins=%h exp req=0 v=1 pc=0 ins=00500093", i, req_a, v_a, pc_a, ins_a);
      end
      step();
    end
    PCWrite = 1'b1; IFIDWrite = 1'b1;
    step();
    n_cmp++;
    if ({v_a, pc_a, ins_a, rs1_a, rs2_a, op_a} !== {1'b1, 32'h4, 32'h0020_8133, 5'd1, 5'd2, 7'h33}) begin
      n_err++; $display("FAIL stall_release got v=%b pc=%h ins=%h exp v=1 pc=4 ins=00208133", v_a, pc_a, ins_a);
    end
    n_cmp++;
    if ({req_a, addr_a} !== {1'b1, 32'h8}) begin
      n_err++; $display("FAIL stall_pc got req=%b addr=%h exp req=1 addr=8", req_a, addr_a);
    end
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h100;
    step();
    redirect_valid = 1'b0;
    n_cmp++;
    if ({req_a, v_a, pc_a, ins_a} !== {1'b0, 1'b0, 32'h4, 32'h13}) begin
      n_err++; $display("FAIL redir_wait_bubble got req=%b v=%b pc=%h ins=%h exp req=0 v=0 pc=4 ins=00000013", req_a, v_a, pc_a, ins_a);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    n_cmp++;
    if ({req_a, addr_a, v_a, ins_a} !== {1'b1, 32'h100, 1'b0, 32'h13}) begin
      n_err++; $display("FAIL redir_wait_drop got req=%b addr=%h v=%b ins=%h exp req=1 addr=100 v=0 ins=00000013", req_a, addr_a, v_a, ins_a);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0513;
    step();
    imem_rvalid = 1'b0;
    n_cmp++;
    if ({v_a, pc_a, ins_a, addr_a} !== {1'b1, 32'h100, 32'h0000_0513, 32'h104}) begin
      n_err++; $display("FAIL redir_target_fetch got v=%b pc=%h ins=%h addr=%h exp v=1 pc=100 ins=00000513 addr=104", v_a, pc_a, ins_a, addr_a);
    end
  endtask

  task automatic test_redirect_gnt();
    redirect_valid = 1'b1; redirect_target = 32'h0000_000F;
    step();
    redirect_valid = 1'b0;
    n_cmp++;
    if ({req_a, addr_a, v_a} !== {1'b1, 32'hC, 1'b0}) begin
      n_err++; $display("FAIL redir_req got req=%b addr=%h v=%b exp req=1 addr=c v=0", req_a, addr_a, v_a);
    end
    imem_gnt = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'h203;
    step();
    imem_gnt = 1'b0; redirect_valid = 1'b0;
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    step();
    imem_rvalid = 1'b0;
    n_cmp++;
    if ({req_a, addr_a, v_a, ins_a} !== {1'b1, 32'h200, 1'b0, 32'h13}) begin
      n_err++; $display("FAIL redir_gnt_drop got req=%b addr=%h v=%b ins=%h exp req=1 addr=200 v=0 ins=00000013", req_a, addr_a, v_a, ins_a);
    end
    step();
    n_cmp++;
    if ({req_a, addr_a} !== {1'b1, 32'h200}) begin
      n_err++; $display("FAIL req_no_gnt got req=%b addr=%h exp req=1 addr=200", req_a, addr_a);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0030_0193;
    step();
    imem_rvalid = 1'b0;
    n_cmp++;
    if ({v_a, pc_a, ins_a, addr_a} !== {1'b1, 32'h200, 32'h0030_0193, 32'h204}) begin
      n_err++; $display("FAIL slow_fetch got v=%b pc=%h ins=%h addr=%h exp v=1 pc=200 ins=00300193 addr=204", v_a, pc_a, ins_a, addr_a);
    end
  endtask

  task automatic test_pcwrite_only_stall();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    PCWrite = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0040_0213;
    step();
    imem_rvalid = 1'b0;
    n_cmp++;
    if ({req_a, v_a, ins_a, addr_a} !== {1'b0, 1'b0, 32'h13, 32'h204}) begin
      n_err++; $display("FAIL pcwrite_stall got req=%b v=%b ins=%h addr=%h exp req=0 v=0 ins=00000013 addr=204", req_a, v_a, ins_a, addr_a);
    end
    PCWrite = 1'b1;
    step();
    n_cmp++;
    if ({v_a, pc_a, ins_a, addr_a} !== {1'b1, 32'h204, 32'h0040_0213, 32'h208}) begin
      n_err++; $display("FAIL pcwrite_release got v=%b pc=%h ins=%h addr=%h exp v=1 pc=204 ins=00400213 addr=208", v_a, pc_a, ins_a, addr_a);
    end
  endtask

  task automatic test_redirect_hold();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    PCWrite = 1'b0; IFIDWrite = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0293;
    step();
    imem_rvalid = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h300;
    step();
    redirect_valid = 1'b0;
    PCWrite = 1'b1; IFIDWrite = 1'b1;
    n_cmp++;
    if ({req_a, addr_a, v_a, ins_a} !== {1'b1, 32'h300, 1'b0, 32'h13}) begin
      n_err++; $display("FAIL redir_hold got req=%b addr=%h v=%b ins=%h exp req=1 addr=300 v=0 ins=00000013", req_a, addr_a, v_a, ins_a);
    end
  endtask

  task automatic test_reset_mid_wait();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    rst = 1'b1;
    step();
    n_cmp++;
    if ({req_a, addr_a, v_a, pc_a, ins_a} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h13}) begin
      n_err++; $display("FAIL reset_mid_wait got req=%b addr=%h v=%b pc=%h ins=%h exp req=0 addr=0 v=0 pc=0 ins=00000013", req_a, addr_a, v_a, pc_a, ins_a);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({req_a, addr_a} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL reset_mid_wait_req got req=%b addr=%h exp req=1 addr=0", req_a, addr_a);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_gnt();
    test_pcwrite_only_stall();
    test_redirect_hold();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the RV32I pipeline. Holds the PC, drives a single-outstanding-request instruction-memory handshake, and owns the IF/ID pipeline register feeding decode and the hazard detection unit. It honours the hazard unit's PCWrite/IFIDWrite stall, and it takes PC redirects from branch/JALR resolution in ID. A redirect squashes wrong-path fetches, including responses still in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on flush or empty slot.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- PCWrite  in  1  from the hazard unit; 0 = freeze PC / do not consume a fetched instruction.
- IFIDWrite  in  1  from the hazard unit; 0 = hold the IF/ID register.
- redirect_valid  in  1  branch taken or JALR resolved in ID this cycle.
- redirect_target  in  32  new PC; bits [1:0] are ignored and forced to 00.
- imem_req  out  1  instruction request valid.
- imem_addr  out  32  request address, equal to the PC while imem_req=1.
- imem_gnt  in  1  memory accepts the request this cycle (imem_req & imem_gnt = handshake).
- imem_rvalid  in  1  response data valid; at most one response per accepted request, never in the same cycle as its grant.
- imem_rdata  in  32  instruction word.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_pc  out  32  PC of the IF/ID instruction.
- ifid_instr  out  32  IF/ID instruction.
- ifid_opcode  out  7  ifid_instr[6:0].
- ifid_rs1  out  5  ifid_instr[19:15].
- ifid_rs2  out  5  ifid_instr[24:20].

## Operation
- Registers: pc, state, kill flag, 32-bit buffer (buf_instr, buf_pc), and the IF/ID register.
- Define consume = PCWrite & IFIDWrite.
- REQ state: imem_req=1, imem_addr=pc.
  - On imem_gnt, go to WAIT.
- WAIT state: imem_req=0.
  - On imem_rvalid with kill=1: discard the data, clear kill, go to REQ.
  - On imem_rvalid with kill=0 and consume=1: load IF/ID with {valid=1, pc, rdata}, set pc<=pc+4 (mod 2^32, wraps to 0), go to REQ.
  - On imem_rvalid with kill=0 and consume=0: store the data in buf, go to HOLD.
- HOLD state: imem_req=0.
  - When consume=1: load IF/ID from buf, set pc<=pc+4, go to REQ.
- IF/ID when no instruction is delivered this cycle:
  - IFIDWrite=1: load a bubble (valid=0, instr=NOP_INSTR, pc unchanged).
  - IFIDWrite=0: hold the current contents.
- Redirect (redirect_valid=1) has priority over everything, including stall:
  - pc<=target; IF/ID <= bubble; buf dropped.
  - In REQ without gnt: stay in REQ; the next request uses the new pc.
  - In REQ with gnt the same cycle: go to WAIT with kill=1, because the stale request's response must be dropped.
  - In WAIT without rvalid: stay in WAIT, set kill=1.
  - In WAIT with rvalid the same cycle: discard the data, go to REQ, kill=0.
  - In HOLD: go to REQ.
- PCWrite=0 with IFIDWrite=1 is legal. The instruction is not consumed; IF/ID receives a bubble.

## Timing
- Reset values: pc=RESET_PC, state=REQ, kill=0, imem_req=0 during the reset cycle, imem_addr=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR (ifid_opcode=7'h13, ifid_rs1=0, ifid_rs2=0).
- First request is presented in the cycle after rst deasserts.
- Latency with an immediate grant and rvalid one cycle later:
  - Cycle 0: REQ with gnt.
  - Cycle 1: rvalid arrives.
  - Edge ending cycle 1: IF/ID updated.
- Peak throughput is one instruction per 2 cycles.
- A reset asserted mid-transaction returns to the reset state in one edge. Any later rvalid from the aborted request is not a legal bus event; the memory model must be reset together with this block.
- All outputs are registered except imem_req/imem_addr (decoded from state/pc) and the ifid_* field slices.

## Test plan
- Reset, memory returns 32'h00500093 at addr 0 with gnt immediate and rvalid 1 cycle later -> IF/ID = {1, 0x0, 0x00500093} at edge 2; next imem_addr=0x4.
- Stall: IFIDWrite=PCWrite=0 for 3 cycles while the response arrives -> state HOLD, IF/ID unchanged, imem_req=0. On release, IF/ID loads the buffered word in 1 edge and pc advances by 4.
- Redirect in WAIT: target 0x100 asserted 1 cycle before rvalid of addr 0x8 -> data for 0x8 never reaches IF/ID; next imem_addr=0x100; ifid_valid=0 in between.
- Redirect coincident with gnt for addr 0xC: target 0x203 -> the 0xC response is discarded, next request address is 0x200.
- Wrap-around: RESET_PC=32'hFFFF_FFFC, one fetch consumed -> next imem_addr=0x0.
- Reset mid-WAIT -> all outputs return to reset values on the next edge; imem_addr=RESET_PC.
